code_conv_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 4-bit combinational code converter.
- Converts a WIDTH-bit word between binary, Gray, BCD and excess-3, with the code selected per beat by a mode input.
- Streams through a two-stage registered pipeline with a valid/ready handshake and flags illegal BCD/excess-3 digits.
- Sits between a data source (switch/counter block) and display or serial logic in the lab datapath.

---
 rtl/conv_pkg.sv | 13 +
 rtl/code_conv_nibble.sv | 26 ++
 rtl/code_conv_pipe.sv | 134 +++++++++++++
 tb/tb_code_conv_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the code_conv_pipe slice.
// Mode encodings and BCD/excess-3 digit constants.
package conv_pkg;

  localparam logic [1:0] MODE_B2G     = 2'd0;
  localparam logic [1:0] MODE_G2B     = 2'd1;
  localparam logic [1:0] MODE_BCD2XS3 = 2'd2;
  localparam logic [1:0] MODE_XS32BCD = 2'd3;

  localparam logic [3:0] XS3_OFFSET    = 4'd3;
  localparam logic [3:0] INVALID_DIGIT = 4'hF;

endpackage

// File: rtl/code_conv_nibble.sv
// Combinational 4-bit BCD <-> excess-3 digit converter.
// Illegal digits produce INVALID_DIGIT with o_err set.
module conv_nibble
  import conv_pkg::*;
(
  input  logic       i_xs3_to_bcd,
  input  logic [3:0] i_d,
  output logic [3:0] o_d,
  output logic       o_err
);

  always_comb begin
    o_d   = INVALID_DIGIT;
    o_err = 1'b1;
    if (!i_xs3_to_bcd) begin
      if (i_d <= 4'd9) begin
        o_d   = i_d + XS3_OFFSET;
        o_err = 1'b0;
      end
    end else if (i_d >= 4'd3 && i_d <= 4'd12) begin
      o_d   = i_d - XS3_OFFSET;
      o_err = 1'b0;
    end
  end

endmodule

// File: rtl/code_conv_pipe.sv
// Two-stage valid/ready binary/Gray/BCD/excess-3 converter.
// Define CONV_ERRCNT_EN to build the saturating err_cnt counter.
module code_conv_pipe
  import conv_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int NIB = WIDTH / 4;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("code_conv_pipe: WIDTH must be a multiple of 4, >= 4");
  end

  logic             r_s1_valid;
  logic [1:0]       r_s1_mode;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;

  logic             w_s2_take;
  logic [WIDTH-1:0] w_gray;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_nib;
  logic [NIB-1:0]   w_nerr;
  logic             w_xs3_dir;
  logic [WIDTH-1:0] w_conv;
  logic             w_err;

  assign w_s2_take = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_take;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= MODE_B2G;
      r_s1_data  <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode <= in_mode;
        r_s1_data <= in_data;
      end
    end
  end

  assign w_gray = r_s1_data ^ (r_s1_data >> 1);

  // Prefix XOR from the MSB down.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    w_bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc      = acc ^ r_s1_data[i];
      w_bin[i] = acc;
    end
  end

  assign w_xs3_dir = (r_s1_mode == MODE_XS32BCD);

  for (genvar g = 0; g < NIB; g++) begin : g_nib
    conv_nibble u_nib (
      .i_xs3_to_bcd (w_xs3_dir),
      .i_d          (r_s1_data[4*g +: 4]),
      .o_d          (w_nib[4*g +: 4]),
      .o_err        (w_nerr[g])
    );
  end

  always_comb begin
    w_conv = w_gray;
    w_err  = 1'b0;
    unique case (r_s1_mode)
      MODE_B2G: w_conv = w_gray;
      MODE_G2B: w_conv = w_bin;
      MODE_BCD2XS3,
      MODE_XS32BCD: begin
        w_conv = w_nib;
        w_err  = |w_nerr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_s2_take) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_conv;
        r_out_err  <= w_err;
      end
    end
  end

`ifdef CONV_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (r_out_valid && out_ready && r_out_err
                 && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_code_conv_pipe.sv
// Directed testbench for code_conv_pipe at WIDTH=8.
// With CONV_ERRCNT_EN the counter is built 2 bits wide.
module tb_code_conv_pipe;
  import conv_pkg::*;

`ifdef CONV_ERRCNT_EN
  localparam int EW = 2;
`else
  localparam int EW = 8;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [7:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_err;
  logic [EW-1:0] err_cnt;

  int compared   = 0;
  int mismatched = 0;

  code_conv_pipe #(.WIDTH(8), .ERRCNT_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single beat into an idle pipe; lat counts rising edges
  // starting with the transfer edge up to out_valid.
  task automatic do_beat(input logic [1:0] m, input logic [7:0] d,
                         output logic [7:0] od, output logic oe,
                         output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_mode   = m;
    in_data   = d;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
    end
    od = out_data;
    oe = out_err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%b d=%h e=%b want v=0 d=00 e=0",
               out_valid, out_data, out_err);
    end
    compared++;
    if (err_cnt !== '0) begin
      mismatched++;
      $display("FAIL reset_errcnt: got %0d want 0", err_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_modes();
    logic [1:0] vm [6] = '{MODE_B2G, MODE_G2B, MODE_BCD2XS3,
                           MODE_BCD2XS3, MODE_XS32BCD, MODE_XS32BCD};
    logic [7:0] vd [6] = '{8'h2D, 8'h3B, 8'h59, 8'h5A, 8'h8C, 8'h8E};
    logic [7:0] ve [6] = '{8'h3B, 8'h2D, 8'h8C, 8'h8F, 8'h59, 8'h5F};
    logic       vr [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] od;
    logic       oe;
    int         lat;
    for (int i = 0; i < 6; i++) begin
      do_beat(vm[i], vd[i], od, oe, lat);
      compared++;
      if (lat !== 2) begin
        mismatched++;
        $display("FAIL latency[%0d]: got %0d want 2", i, lat);
      end
      compared++;
      if (od !== ve[i] || oe !== vr[i]) begin
        mismatched++;
        $display("FAIL mode%0d_%h: got d=%h e=%b want d=%h e=%b",
                 vm[i], vd[i], od, oe, ve[i], vr[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] g;
    logic [7:0] b;
    logic       oe;
    int         lat;
    for (int v = 0; v < 256; v++) begin
      do_beat(MODE_B2G, 8'(v), g, oe, lat);
      do_beat(MODE_G2B, g, b, oe, lat);
      compared++;
      if (b !== 8'(v)) begin
        mismatched++;
        $display("FAIL gray_roundtrip: got %h want %h", b, 8'(v));
      end
    end
  endtask

  task automatic test_stream();
    int         acc = 0;
    int         emitted = 0;
    int         cyc = 0;
    logic       stalled_prev = 1'b0;
    logic       saw_full = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       tin;
    logic       tout;
    while (emitted < 10 && cyc < 60) begin
      @(negedge clk);
      in_valid  = (acc < 10);
      in_mode   = MODE_BCD2XS3;
      in_data   = 8'h10 + acc[7:0];
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (acc - emitted == 2 && !out_ready) begin
        saw_full = 1'b1;
        compared++;
        if (in_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL stream_full_ready cyc%0d: got %b want 0",
                   cyc, in_ready);
        end
      end
      if (stalled_prev) begin
        compared++;
        if (out_valid !== 1'b1 || out_data !== prev_d) begin
          mismatched++;
          $display("FAIL stream_hold cyc%0d: got v=%b d=%h want v=1 d=%h",
                   cyc, out_valid, out_data, prev_d);
        end
      end
      tin  = in_valid && in_ready;
      tout = out_valid && out_ready;
      if (tout) begin
        compared++;
        if (out_data !== 8'h43 + emitted[7:0] || out_err !== 1'b0) begin
          mismatched++;
          $display("FAIL stream_beat%0d: got d=%h e=%b want d=%h e=0",
                   emitted, out_data, out_err, 8'h43 + emitted[7:0]);
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev_d       = out_data;
      @(posedge clk);
      if (tin) acc++;
      if (tout) emitted++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    compared++;
    if (emitted != 10 || !saw_full) begin
      mismatched++;
      $display("FAIL stream_done: got %0d beats full=%b want 10 full=1",
               emitted, saw_full);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] bm [4] = '{MODE_B2G, MODE_BCD2XS3, MODE_G2B, MODE_XS32BCD};
    logic [7:0] bd [4] = '{8'h2D, 8'h59, 8'h3B, 8'h8C};
    logic [7:0] be [4] = '{8'h3B, 8'h8C, 8'h2D, 8'h59};
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      in_valid  = (cyc < 4);
      out_ready = 1'b1;
      if (cyc < 4) begin
        in_mode = bm[cyc];
        in_data = bd[cyc];
      end
      #1;
      if (cyc < 4) begin
        compared++;
        if (in_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL b2b_ready cyc%0d: got %b want 1", cyc, in_ready);
        end
      end
      if (cyc >= 2 && cyc < 6) begin
        compared++;
        if (out_valid !== 1'b1 || out_data !== be[cyc-2]) begin
          mismatched++;
          $display("FAIL b2b_out%0d: got v=%b d=%h want v=1 d=%h",
                   cyc - 2, out_valid, out_data, be[cyc-2]);
        end
      end
      @(posedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    in_valid  = 1'b1;
    in_mode   = MODE_B2G;
    in_data   = 8'h2D;
    out_ready = 1'b0;
    @(negedge clk);
    in_data = 8'h3B;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_inflight: got v=%b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_async: got v=%b d=%h e=%b want v=0 d=00 e=0",
               out_valid, out_data, out_err);
    end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL midrst_stale%0d: got v=%b want 0", i, out_valid);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_errcnt();
    logic [7:0] od;
    logic       oe;
    int         lat;
`ifdef CONV_ERRCNT_EN
    for (int i = 0; i < 2; i++) do_beat(MODE_BCD2XS3, 8'hAA, od, oe, lat);
    compared++;
    if (err_cnt !== 2'd2) begin
      mismatched++;
      $display("FAIL errcnt_two: got %0d want 2", err_cnt);
    end
    do_beat(MODE_B2G, 8'hAA, od, oe, lat);
    for (int i = 0; i < 3; i++) do_beat(MODE_XS32BCD, 8'h00, od, oe, lat);
    compared++;
    if (err_cnt !== 2'd3) begin
      mismatched++;
      $display("FAIL errcnt_sat: got %0d want 3", err_cnt);
    end
`else
    do_beat(MODE_BCD2XS3, 8'hAA, od, oe, lat);
    compared++;
    if (err_cnt !== '0 || oe !== 1'b1) begin
      mismatched++;
      $display("FAIL errcnt_tied: got cnt=%0d e=%b want cnt=0 e=1",
               err_cnt, oe);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_modes();
    test_sweep();
    test_stream();
    test_back_to_back();
    test_reset_midstream();
    test_errcnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
